ctrl_hazard_unit: RTL and testbench



---
 rtl/ctrl_hazard_unit.sv | 185 ++++++++++++++++++
 tb/tb_ctrl_hazard_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_hazard_unit.sv
// Hazard controller for the five-stage MIPS core: shadow E/M/W pipeline, D-stage stall, D/E forwarding selects.
// Optional feature: define CTRL_HAZARD_STALL_CNT_EN to add the saturating stall_cnt output.
module ctrl_hazard_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [1:0]  tuse_rs_d,
    input  logic [1:0]  tuse_rt_d,
    input  logic        we_d,
    input  logic [4:0]  a3_d,
    input  logic [1:0]  tnew_e_d,
    output logic        stall,
    output logic [1:0]  fwd_rs_d_sel,
    output logic [1:0]  fwd_rt_d_sel,
    output logic [1:0]  fwd_rs_e_sel,
    output logic [1:0]  fwd_rt_e_sel
`ifdef CTRL_HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_W    = 2'b01;
    localparam logic [1:0] SEL_M    = 2'b10;
    localparam logic [1:0] SEL_E    = 2'b11;

    // Shadow pipeline; W carries no Tnew because it is always zero there.
    logic        ex_we_q,   ex_we_d;
    logic [4:0]  ex_a3_q,   ex_a3_d;
    logic [1:0]  ex_tnew_q, ex_tnew_d;
    logic [4:0]  ex_rs_q,   ex_rs_d;
    logic [4:0]  ex_rt_q,   ex_rt_d;
    logic        mem_we_q,   mem_we_d;
    logic [4:0]  mem_a3_q,   mem_a3_d;
    logic [1:0]  mem_tnew_q, mem_tnew_d;
    logic        wb_we_q,  wb_we_d;
    logic [4:0]  wb_a3_q,  wb_a3_d;

    logic e_rs_hit_s, m_rs_hit_s, w_rs_hit_s;
    logic e_rt_hit_s, m_rt_hit_s, w_rt_hit_s;
    logic m_rse_hit_s, w_rse_hit_s;
    logic m_rte_hit_s, w_rte_hit_s;
    logic stall_rs_s, stall_rt_s;

    function automatic logic writes_reg(input logic we, input logic [4:0] a3, input logic [4:0] r);
        return we && (a3 == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] d_select(input logic e_hit, input logic [1:0] e_tnew,
                                            input logic m_hit, input logic [1:0] m_tnew,
                                            input logic w_hit);
        logic [1:0] sel;
        if (e_hit && (e_tnew == 2'd0)) begin
            sel = SEL_E;
        end else if (m_hit && (m_tnew == 2'd0)) begin
            sel = SEL_M;
        end else if (w_hit) begin
            sel = SEL_W;
        end else begin
            sel = SEL_BASE;
        end
        return sel;
    endfunction

    function automatic logic [1:0] e_select(input logic m_hit, input logic [1:0] m_tnew,
                                            input logic w_hit);
        logic [1:0] sel;
        if (m_hit && (m_tnew == 2'd0)) begin
            sel = SEL_M;
        end else if (w_hit) begin
            sel = SEL_W;
        end else begin
            sel = SEL_BASE;
        end
        return sel;
    endfunction

    // Register matches, stall decision and forwarding selects from shadow state and D inputs.
    always_comb begin
        e_rs_hit_s  = writes_reg(ex_we_q,  ex_a3_q,  rs_d);
        m_rs_hit_s  = writes_reg(mem_we_q, mem_a3_q, rs_d);
        w_rs_hit_s  = writes_reg(wb_we_q,  wb_a3_q,  rs_d);
        e_rt_hit_s  = writes_reg(ex_we_q,  ex_a3_q,  rt_d);
        m_rt_hit_s  = writes_reg(mem_we_q, mem_a3_q, rt_d);
        w_rt_hit_s  = writes_reg(wb_we_q,  wb_a3_q,  rt_d);
        m_rse_hit_s = writes_reg(mem_we_q, mem_a3_q, ex_rs_q);
        w_rse_hit_s = writes_reg(wb_we_q,  wb_a3_q,  ex_rs_q);
        m_rte_hit_s = writes_reg(mem_we_q, mem_a3_q, ex_rt_q);
        w_rte_hit_s = writes_reg(wb_we_q,  wb_a3_q,  ex_rt_q);

        // Tuse of 3 (not read) can never be exceeded since Tnew tops out at 2.
        stall_rs_s = (e_rs_hit_s && (ex_tnew_q > tuse_rs_d)) ||
                     (m_rs_hit_s && (mem_tnew_q > tuse_rs_d));
        stall_rt_s = (e_rt_hit_s && (ex_tnew_q > tuse_rt_d)) ||
                     (m_rt_hit_s && (mem_tnew_q > tuse_rt_d));
        stall      = stall_rs_s || stall_rt_s;

        fwd_rs_d_sel = d_select(e_rs_hit_s, ex_tnew_q, m_rs_hit_s, mem_tnew_q, w_rs_hit_s);
        fwd_rt_d_sel = d_select(e_rt_hit_s, ex_tnew_q, m_rt_hit_s, mem_tnew_q, w_rt_hit_s);
        fwd_rs_e_sel = e_select(m_rse_hit_s, mem_tnew_q, w_rse_hit_s);
        fwd_rt_e_sel = e_select(m_rte_hit_s, mem_tnew_q, w_rte_hit_s);
    end

    // Next shadow state: E takes D or a bubble, M and W shift unconditionally.
    always_comb begin
        if (stall) begin
            ex_we_d   = 1'b0;
            ex_a3_d   = 5'd0;
            ex_tnew_d = 2'd0;
            ex_rs_d   = 5'd0;
            ex_rt_d   = 5'd0;
        end else begin
            ex_we_d   = we_d;
            ex_a3_d   = a3_d;
            ex_tnew_d = tnew_e_d;
            ex_rs_d   = rs_d;
            ex_rt_d   = rt_d;
        end

        mem_we_d = ex_we_q;
        mem_a3_d = ex_a3_q;
        if (ex_tnew_q == 2'd0) begin
            mem_tnew_d = 2'd0;
        end else begin
            mem_tnew_d = ex_tnew_q - 2'd1;
        end

        wb_we_d = mem_we_q;
        wb_a3_d = mem_a3_q;
    end

    // Shadow pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_we_q    <= 1'b0;
            ex_a3_q    <= 5'd0;
            ex_tnew_q  <= 2'd0;
            ex_rs_q    <= 5'd0;
            ex_rt_q    <= 5'd0;
            mem_we_q   <= 1'b0;
            mem_a3_q   <= 5'd0;
            mem_tnew_q <= 2'd0;
            wb_we_q    <= 1'b0;
            wb_a3_q    <= 5'd0;
        end else begin
            ex_we_q    <= ex_we_d;
            ex_a3_q    <= ex_a3_d;
            ex_tnew_q  <= ex_tnew_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            mem_we_q   <= mem_we_d;
            mem_a3_q   <= mem_a3_d;
            mem_tnew_q <= mem_tnew_d;
            wb_we_q    <= wb_we_d;
            wb_a3_q    <= wb_a3_d;
        end
    end

`ifdef CTRL_HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_hazard_unit.sv
// Randomized and directed bench for ctrl_hazard_unit against an instruction-level reference model.
module tb_ctrl_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_d, rt_d, a3_d;
    logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e_d;
    logic        we_d;
    logic        stall;
    logic [1:0]  fwd_rs_d_sel, fwd_rt_d_sel, fwd_rs_e_sel, fwd_rt_e_sel;
`ifdef CTRL_HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    ctrl_hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .tuse_rs_d    (tuse_rs_d),
        .tuse_rt_d    (tuse_rt_d),
        .we_d         (we_d),
        .a3_d         (a3_d),
        .tnew_e_d     (tnew_e_d),
        .stall        (stall),
        .fwd_rs_d_sel (fwd_rs_d_sel),
        .fwd_rt_d_sel (fwd_rt_d_sel),
        .fwd_rs_e_sel (fwd_rs_e_sel),
        .fwd_rt_e_sel (fwd_rt_e_sel)
`ifdef CTRL_HAZARD_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: each in-flight instruction remembers the absolute cycle its result becomes ready.
    typedef struct {
        bit       we;
        bit [4:0] a3;
        int       ready;
        bit [4:0] rs;
        bit [4:0] rt;
    } ent_t;

    ent_t    pipe[$];   // index 0 = E, 1 = M, 2 = W
    int      now;
    longint  model_cnt;
    int      stall_run;
    int      n_checks;
    int      n_fail;

    function automatic ent_t bubble();
        ent_t e;
        e.we = 0; e.a3 = 0; e.ready = 0; e.rs = 0; e.rt = 0;
        return e;
    endfunction

    function automatic void model_reset();
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(bubble());
        now = 0;
        model_cnt = 0;
        stall_run = 0;
    endfunction

    function automatic int remaining(int i);
        return (pipe[i].ready > now) ? pipe[i].ready - now : 0;
    endfunction

    function automatic bit wr(int i, bit [4:0] r);
        return pipe[i].we && (pipe[i].a3 == r) && (r != 0);
    endfunction

    function automatic bit need_stall(bit [4:0] r, int tuse);
        for (int i = 0; i < 2; i++)
            if (wr(i, r) && remaining(i) > tuse) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        return need_stall(rs_d, int'(tuse_rs_d)) || need_stall(rt_d, int'(tuse_rt_d));
    endfunction

    function automatic int model_dsel(bit [4:0] r);
        if (wr(0, r) && remaining(0) == 0) return 3;
        if (wr(1, r) && remaining(1) == 0) return 2;
        if (wr(2, r)) return 1;
        return 0;
    endfunction

    function automatic int model_esel(bit [4:0] r);
        if (wr(1, r) && remaining(1) == 0) return 2;
        if (wr(2, r)) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_now();
        chk("stall",        stall,        model_stall());
        chk("fwd_rs_d_sel", fwd_rs_d_sel, model_dsel(rs_d));
        chk("fwd_rt_d_sel", fwd_rt_d_sel, model_dsel(rt_d));
        chk("fwd_rs_e_sel", fwd_rs_e_sel, model_esel(pipe[0].rs));
        chk("fwd_rt_e_sel", fwd_rt_e_sel, model_esel(pipe[0].rt));
`ifdef CTRL_HAZARD_STALL_CNT_EN
        chk("stall_cnt",    stall_cnt,    model_cnt);
`endif
    endtask

    task automatic drive(input bit [4:0] rs, input bit [4:0] rt, input bit [1:0] tus,
                         input bit [1:0] tut, input bit we, input bit [4:0] a3, input bit [1:0] tn);
        @(negedge clk);
        rs_d = rs; rt_d = rt; tuse_rs_d = tus; tuse_rt_d = tut;
        we_d = we; a3_d = a3; tnew_e_d = tn;
        #1;
        compare_now();
    endtask

    task automatic advance();
        ent_t e;
        bit   s;
        @(posedge clk);
        s = model_stall();
        if (s) begin
            if (model_cnt < 64'hFFFF_FFFF) model_cnt++;
            stall_run++;
            chk("stall_run_max2", stall_run <= 2, 1);
        end else begin
            stall_run = 0;
        end
        now++;
        if (s) begin
            e = bubble();
        end else begin
            e.we = we_d; e.a3 = a3_d; e.ready = now + int'(tnew_e_d); e.rs = rs_d; e.rt = rt_d;
        end
        pipe.push_front(e);
        void'(pipe.pop_back());
    endtask

    task automatic step(input bit [4:0] rs, input bit [4:0] rt, input bit [1:0] tus,
                        input bit [1:0] tut, input bit we, input bit [4:0] a3, input bit [1:0] tn);
        drive(rs, rt, tus, tut, we, a3, tn);
        advance();
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0);
    endtask

    initial begin
        bit held;
        bit [4:0] r_rs, r_rt, r_a3;
        bit [1:0] r_tus, r_tut, r_tn;
        bit       r_we;

        n_checks = 0;
        n_fail   = 0;
        model_reset();

        // Reset state: outputs must be idle even with a D instruction reading registers.
        rst_n = 1'b0;
        rs_d = 5'd1; rt_d = 5'd2; tuse_rs_d = 2'd0; tuse_rt_d = 2'd0;
        we_d = 1'b1; a3_d = 5'd1; tnew_e_d = 2'd2;
        #12;
        chk("reset_stall",  stall,        0);
        chk("reset_rs_d",   fwd_rs_d_sel, 0);
        chk("reset_rt_d",   fwd_rt_d_sel, 0);
        chk("reset_rs_e",   fwd_rs_e_sel, 0);
        chk("reset_rt_e",   fwd_rt_e_sel, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lw $1 then dependent ALU op: one stall, then E-stage forward from W.
        flush();
        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd1, 2'd2);
        drive(5'd1, 5'd0, 2'd1, 2'd3, 1'b1, 5'd4, 2'd1);
        chk("tp1_stall_pin", model_stall(), 1);
        advance();
        drive(5'd1, 5'd0, 2'd1, 2'd3, 1'b1, 5'd4, 2'd1);
        chk("tp1_release_pin", model_stall(), 0);
        advance();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0);
        chk("tp1_fwd_rs_e_pin", model_esel(pipe[0].rs), 1);
        chk("tp1_fwd_rs_e_dut", fwd_rs_e_sel, 1);
        advance();

        // addu $2 then beq $2,$2: one stall, then both D selects from M.
        flush();
        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd2, 2'd1);
        drive(5'd2, 5'd2, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
        chk("tp2_stall_pin", model_stall(), 1);
        advance();
        drive(5'd2, 5'd2, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
        chk("tp2_release_dut", stall, 0);
        chk("tp2_rs_d_pin", model_dsel(rs_d), 2);
        chk("tp2_rt_d_dut", fwd_rt_d_sel, 2);
        advance();

        // jal then jr $31: forward from E, no stall.
        flush();
        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd31, 2'd0);
        drive(5'd31, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0);
        chk("tp3_stall_dut", stall, 0);
        chk("tp3_rs_d_pin", model_dsel(rs_d), 3);
        advance();

        // lw then beq on the same register: two stalls.
        flush();
        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd7, 2'd2);
        for (int i = 0; i < 3; i++) begin
            drive(5'd7, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0);
            chk("lw_beq_stall_dut", stall, (i < 2) ? 1 : 0);
            advance();
        end

        // Writers to $0 everywhere never match.
        flush();
        for (int i = 0; i < 3; i++) step(5'd0, 5'd0, 2'd0, 2'd0, 1'b1, 5'd0, 2'd0);
        drive(5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
        chk("tp4_stall_dut", stall, 0);
        chk("tp4_rs_d_dut", fwd_rs_d_sel, 0);
        chk("tp4_rt_d_dut", fwd_rt_d_sel, 0);
        advance();

        // ori $3 in W, addu $3 in M: M wins.
        flush();
        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd3, 2'd1);
        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd3, 2'd1);
        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0);
        drive(5'd3, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd0);
        chk("tp5_rs_d_pin", model_dsel(rs_d), 2);
        chk("tp5_rs_d_dut", fwd_rs_d_sel, 2);
        advance();

        // Reset pulse between edges while stalled.
        flush();
        step(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd5, 2'd2);
        drive(5'd5, 5'd5, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0);
        chk("tp6_pre_stall_dut", stall, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("tp6_stall_dut", stall, 0);
        chk("tp6_rs_d_dut", fwd_rs_d_sel, 0);
        chk("tp6_rt_d_dut", fwd_rt_d_sel, 0);
        chk("tp6_rs_e_dut", fwd_rs_e_sel, 0);
        chk("tp6_rt_e_dut", fwd_rt_e_sel, 0);
`ifdef CTRL_HAZARD_STALL_CNT_EN
        chk("tp6_stall_cnt_dut", stall_cnt, 0);
`endif
        model_reset();
        rst_n = 1'b1;
        #1;
        compare_now();
        advance();

        // Random traffic over a small register set; D is held while stalled.
        held = 0;
        r_rs = 0; r_rt = 0; r_a3 = 0; r_tus = 3; r_tut = 3; r_tn = 0; r_we = 0;
        for (int i = 0; i < 800; i++) begin
            if (!held) begin
                r_rs  = 5'($urandom_range(0, 3));
                r_rt  = 5'($urandom_range(0, 3));
                r_tus = 2'($urandom_range(0, 3));
                r_tut = 2'($urandom_range(0, 3));
                r_we  = 1'($urandom_range(0, 1));
                r_a3  = 5'($urandom_range(0, 3));
                r_tn  = 2'($urandom_range(0, 2));
            end
            drive(r_rs, r_rt, r_tus, r_tut, r_we, r_a3, r_tn);
            held = model_stall();
            advance();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
